wf68k30l_bus_target: RTL and testbench

- Memory-mapped 32-bit bus responder (slave) for the WF68K30L external bus: the target end of the MC68030 asynchronous/synchronous bus protocol.
- Decodes AS/DS cycles, generates byte-lane enables from SIZE/A1:0, and drives a simple synchronous RAM port.
- Terminates cycles with DSACKn (32-bit port) or STERMn, supports 4-beat cache bursts via CBACKn, and asserts BERRn on unmapped addresses.
- Used in simulation benches and FPGA systems as main-memory model.

---
 rtl/wf68k30l_bus_target_if.sv | 27 ++
 rtl/wf68k30l_bus_target.sv | 181 ++++++++++++++++++
 tb/tb_wf68k30l_bus_target.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wf68k30l_bus_target_if.sv
// CPU-side bus bundle of the WF68K30L external bus as seen by a memory target.
// Both strobes and terminations are active low.
interface wf68k30l_bus_target_if;
    logic [31:0] adr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_en;
    logic        asn;
    logic        dsn;
    logic        rwn;
    logic [1:0]  size;
    logic        cbreqn;
    logic [1:0]  dsackn;
    logic        stermn;
    logic        cbackn;
    logic        berrn;

    modport master (
        output adr_in, data_in, asn, dsn, rwn, size, cbreqn,
        input  data_out, data_en, dsackn, stermn, cbackn, berrn
    );

    modport slave (
        input  adr_in, data_in, asn, dsn, rwn, size, cbreqn,
        output data_out, data_en, dsackn, stermn, cbackn, berrn
    );
endinterface

// File: rtl/wf68k30l_bus_target.sv
// WF68K30L bus target: decodes AS cycles onto a synchronous RAM port and terminates
// them with DSACKn or STERMn, including 4-beat cache burst fills and bus errors.
//
//   state  | meaning
//   IDLE   | waiting for ASn low, decodes the address window
//   ACCESS | one-cycle RAM read or write strobe
//   SETTLE | wait states; read data captured on exit
//   TERM   | termination asserted (DSACKn until ASn high, or one STERMn beat)
//   BURST  | three further STERMn beats with wrapped longword index
//   HOLD   | synchronous cycle done, waiting for ASn high
//   ERR    | BERRn asserted until ASn high
module wf68k30l_bus_target #(
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          ADR_BITS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter bit          SYNC_TERM   = 1'b0,
    parameter bit          BURST_EN    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    wf68k30l_bus_target_if.slave     bus,
    output logic [ADR_BITS-3:0]      mem_adr,
    output logic [3:0]               mem_be,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);
    typedef enum logic [2:0] {IDLE, ACCESS, SETTLE, TERM, BURST, HOLD, ERR} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state;
    logic        rw_r;
    logic        burst_r;
    logic [3:0]  wait_cnt;
    logic [1:0]  beat_cnt;

    logic [32:0] adr_diff;
    logic        in_window;
    logic [2:0]  nbytes;
    logic [3:0]  lane_mask;
    logic        burst_req;
    logic        unused_dsn;

    assign adr_diff   = {1'b0, bus.adr_in} - {1'b0, BASE_ADR};
    assign in_window  = !adr_diff[32] && ((adr_diff[31:0] >> ADR_BITS) == 32'd0);
    assign nbytes     = (bus.size == 2'b00) ? 3'd4 : {1'b0, bus.size};
    // n ones left-justified, then shifted down to the starting byte; overflow lanes fall off
    assign lane_mask  = 4'((4'b1111 << (3'd4 - nbytes)) >> bus.adr_in[1:0]);
    assign burst_req  = SYNC_TERM && BURST_EN && bus.rwn && (bus.size == 2'b00) && !bus.cbreqn;
    assign mem_wdata  = bus.data_in;
    assign unused_dsn = bus.dsn;

    // Burst reads run one RAM access ahead: the next beat is fetched in the cycle the
    // current beat's data is being captured, so every prefetch bumps the index in A3:2.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rw_r         <= 1'b1;
            burst_r      <= 1'b0;
            wait_cnt     <= 4'd0;
            beat_cnt     <= 2'd0;
            mem_adr      <= '0;
            mem_be       <= 4'b0000;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            bus.data_out <= 32'd0;
            bus.data_en  <= 1'b0;
            bus.dsackn   <= 2'b11;
            bus.stermn   <= 1'b1;
            bus.cbackn   <= 1'b1;
            bus.berrn    <= 1'b1;
        end else begin
            case (state)
                IDLE: if (!bus.asn) begin
                    if (!in_window) begin
                        bus.berrn <= 1'b0;
                        state     <= ERR;
                    end else begin
                        rw_r    <= bus.rwn;
                        burst_r <= burst_req;
                        mem_adr <= adr_diff[ADR_BITS-1:2];
                        mem_be  <= lane_mask;
                        mem_re  <= bus.rwn;
                        mem_we  <= !bus.rwn;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we   <= 1'b0;
                    wait_cnt <= WS;
                    if (bus.asn) begin
                        mem_re <= 1'b0;
                        mem_be <= 4'b0000;
                        state  <= IDLE;
                    end else begin
                        mem_re <= burst_r && (WS == 4'd0);
                        if (burst_r && (WS == 4'd0))
                            mem_adr[1:0] <= mem_adr[1:0] + 2'd1;
                        state <= SETTLE;
                    end
                end
                SETTLE: if (bus.asn) begin
                    mem_re <= 1'b0;
                    mem_be <= 4'b0000;
                    state  <= IDLE;
                end else if (wait_cnt == 4'd0) begin
                    if (rw_r) begin
                        bus.data_out <= mem_rdata;
                        bus.data_en  <= 1'b1;
                    end
                    if (SYNC_TERM) begin
                        bus.stermn <= 1'b0;
                        bus.cbackn <= !burst_r;
                    end else begin
                        bus.dsackn <= 2'b00;
                    end
                    mem_re <= burst_r;
                    if (burst_r)
                        mem_adr[1:0] <= mem_adr[1:0] + 2'd1;
                    state <= TERM;
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                    mem_re   <= burst_r && (wait_cnt == 4'd1);
                    if (burst_r && (wait_cnt == 4'd1))
                        mem_adr[1:0] <= mem_adr[1:0] + 2'd1;
                end
                TERM: if (SYNC_TERM) begin
                    if (burst_r && !bus.asn) begin
                        bus.data_out <= mem_rdata;
                        mem_re       <= 1'b1;
                        mem_adr[1:0] <= mem_adr[1:0] + 2'd1;
                        beat_cnt     <= 2'd1;
                        state        <= BURST;
                    end else begin
                        bus.stermn <= 1'b1;
                        bus.cbackn <= 1'b1;
                        mem_re     <= 1'b0;
                        state      <= HOLD;
                    end
                end else if (bus.asn) begin
                    bus.dsackn  <= 2'b11;
                    bus.data_en <= 1'b0;
                    mem_be      <= 4'b0000;
                    state       <= IDLE;
                end
                BURST: begin
                    mem_re <= 1'b0;
                    if (bus.asn || beat_cnt == 2'd3) begin
                        bus.stermn <= 1'b1;
                        bus.cbackn <= 1'b1;
                        beat_cnt   <= 2'd0;
                        if (bus.asn) begin
                            bus.data_en <= 1'b0;
                            mem_be      <= 4'b0000;
                            state       <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        bus.data_out <= mem_rdata;
                        beat_cnt     <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd2)
                            bus.cbackn <= 1'b1;
                    end
                end
                HOLD: if (bus.asn) begin
                    bus.data_en <= 1'b0;
                    mem_be      <= 4'b0000;
                    state       <= IDLE;
                end
                ERR: if (bus.asn) begin
                    bus.berrn <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wf68k30l_bus_target.sv
// Bench for wf68k30l_bus_target: three instances (async 0 wait, async 3 waits at 0x400,
// synchronous with bursts) against RAM models and a shadow memory of expected contents.
module tb_wf68k30l_bus_target;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] adr, wdata;
    logic        rwn, dsn, cbreqn;
    logic [1:0]  size;
    logic        asn_v [3];

    wf68k30l_bus_target_if bus0 ();
    wf68k30l_bus_target_if bus1 ();
    wf68k30l_bus_target_if bus2 ();

    assign bus0.adr_in = adr;  assign bus1.adr_in = adr;  assign bus2.adr_in = adr;
    assign bus0.data_in = wdata; assign bus1.data_in = wdata; assign bus2.data_in = wdata;
    assign bus0.rwn = rwn;     assign bus1.rwn = rwn;     assign bus2.rwn = rwn;
    assign bus0.dsn = dsn;     assign bus1.dsn = dsn;     assign bus2.dsn = dsn;
    assign bus0.size = size;   assign bus1.size = size;   assign bus2.size = size;
    assign bus0.cbreqn = cbreqn; assign bus1.cbreqn = cbreqn; assign bus2.cbreqn = cbreqn;
    assign bus0.asn = asn_v[0]; assign bus1.asn = asn_v[1]; assign bus2.asn = asn_v[2];

    logic [31:0] dout [3];
    logic        den [3], sterm [3], cback [3], berr [3];
    logic [1:0]  dsk [3];
    logic [5:0]  madr [3];
    logic [3:0]  mbe [3];
    logic        mwe [3], mre [3];
    logic [31:0] mwd [3], mrd [3];

    assign dout[0] = bus0.data_out; assign dout[1] = bus1.data_out; assign dout[2] = bus2.data_out;
    assign den[0] = bus0.data_en;   assign den[1] = bus1.data_en;   assign den[2] = bus2.data_en;
    assign dsk[0] = bus0.dsackn;    assign dsk[1] = bus1.dsackn;    assign dsk[2] = bus2.dsackn;
    assign sterm[0] = bus0.stermn;  assign sterm[1] = bus1.stermn;  assign sterm[2] = bus2.stermn;
    assign cback[0] = bus0.cbackn;  assign cback[1] = bus1.cbackn;  assign cback[2] = bus2.cbackn;
    assign berr[0] = bus0.berrn;    assign berr[1] = bus1.berrn;    assign berr[2] = bus2.berrn;

    wf68k30l_bus_target #(.BASE_ADR(32'h0), .ADR_BITS(8), .WAIT_STATES(0), .SYNC_TERM(1'b0), .BURST_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .mem_adr(madr[0]), .mem_be(mbe[0]),
        .mem_we(mwe[0]), .mem_re(mre[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]));
    wf68k30l_bus_target #(.BASE_ADR(32'h400), .ADR_BITS(8), .WAIT_STATES(3), .SYNC_TERM(1'b0), .BURST_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .mem_adr(madr[1]), .mem_be(mbe[1]),
        .mem_we(mwe[1]), .mem_re(mre[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]));
    wf68k30l_bus_target #(.BASE_ADR(32'h0), .ADR_BITS(8), .WAIT_STATES(0), .SYNC_TERM(1'b1), .BURST_EN(1'b1)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .mem_adr(madr[2]), .mem_be(mbe[2]),
        .mem_we(mwe[2]), .mem_re(mre[2]), .mem_wdata(mwd[2]), .mem_rdata(mrd[2]));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[3-i]) r[31-8*i -: 8] = nw[31-8*i -: 8];
        return r;
    endfunction

    // RAM models: read data appears the cycle after the strobe and holds until the next one
    logic [31:0] ram0 [64], ram1 [64], ram2 [64];
    int          strobes [3];
    initial for (int k = 0; k < 3; k++) strobes[k] = 0;
    always @(posedge clk) begin
        if (mwe[0]) ram0[madr[0]] <= merge(ram0[madr[0]], mwd[0], mbe[0]);
        if (mre[0]) mrd[0] <= ram0[madr[0]];
        if (mwe[1]) ram1[madr[1]] <= merge(ram1[madr[1]], mwd[1], mbe[1]);
        if (mre[1]) mrd[1] <= ram1[madr[1]];
        if (mwe[2]) ram2[madr[2]] <= merge(ram2[madr[2]], mwd[2], mbe[2]);
        if (mre[2]) mrd[2] <= ram2[madr[2]];
        for (int k = 0; k < 3; k++) strobes[k] <= strobes[k] + int'(mwe[k]) + int'(mre[k]);
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          ws_of [3] = '{0, 3, 0};
    logic [31:0] base_of [3] = '{32'h0, 32'h400, 32'h0};
    logic [31:0] ref_mem [3][16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte lanes o .. o+n-1 clipped at lane 3; bit 3 is byte offset 0
    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
        int n, o;
        logic [3:0] be;
        n  = (sz == 2'b00) ? 4 : int'(sz);
        o  = int'(a[1:0]);
        be = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= o && i < o + n) be[3-i] = 1'b1;
        return be;
    endfunction

    function automatic int widx(input int k, input logic [31:0] a);
        return int'(((a - base_of[k]) >> 2) & 32'd15);
    endfunction

    task automatic async_xfer(input int k, input logic [31:0] a, input logic rw,
                              input logic [1:0] sz, input logic [31:0] wd, input int hold);
        int n;
        adr = a; rwn = rw; size = sz; wdata = wd; dsn = 1'b0; cbreqn = 1'b1;
        asn_v[k] = 1'b0;
        tick();
        chk("access_strobe", {mre[k], mwe[k]}, rw ? 2'b10 : 2'b01);
        chk("lane_be", mbe[k], exp_be(a, sz));
        if (!rw) ref_mem[k][widx(k, a)] = merge(ref_mem[k][widx(k, a)], wd, exp_be(a, sz));
        tick();
        chk("strobe_one_shot", {mre[k], mwe[k]}, 2'b00);
        n = 1;
        while (dsk[k] != 2'b00 && n < 30) begin
            tick();
            n++;
        end
        chk("term_latency", n, 2 + ws_of[k]);
        if (rw) begin
            chk("read_data", dout[k], ref_mem[k][widx(k, a)]);
            chk("data_en", den[k], 1'b1);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("dsack_held", dsk[k], 2'b00);
        end
        asn_v[k] = 1'b1; dsn = 1'b1;
        tick();
        chk("async_release", {dsk[k], den[k]}, 3'b110);
    endtask

    task automatic sync_xfer(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                             input logic [31:0] wd, input logic cbreq);
        int n, beats, wi;
        logic grant;
        grant = rw && (sz == 2'b00) && !cbreq;
        adr = a; rwn = rw; size = sz; wdata = wd; dsn = 1'b0; cbreqn = cbreq;
        asn_v[2] = 1'b0;
        tick();
        chk("sync_strobe", {mre[2], mwe[2]}, rw ? 2'b10 : 2'b01);
        if (!rw) ref_mem[2][widx(2, a)] = merge(ref_mem[2][widx(2, a)], wd, exp_be(a, sz));
        tick();
        n = 1;
        while (sterm[2] != 1'b0 && n < 30) begin
            tick();
            n++;
        end
        chk("sync_latency", n, 2);
        beats = 0;
        while (sterm[2] == 1'b0 && beats < 6) begin
            wi = int'((((a >> 2) & ~32'd3) | (((a >> 2) + beats) & 32'd3)) & 32'd15);
            if (rw) chk("beat_data", dout[2], ref_mem[2][wi]);
            chk("beat_cback", cback[2], grant ? (beats == 3) : 1);
            beats++;
            tick();
        end
        chk("beat_count", beats, grant ? 4 : 1);
        asn_v[2] = 1'b1; dsn = 1'b1;
        tick();
        chk("sync_release", {sterm[2], cback[2], den[2]}, 3'b110);
    endtask

    task automatic err_xfer(input int k, input logic [31:0] a);
        int s0;
        s0 = strobes[k];
        adr = a; rwn = 1'b1; size = 2'b00; cbreqn = 1'b1;
        asn_v[k] = 1'b0;
        tick();
        chk("berr_assert", {berr[k], dsk[k]}, 3'b011);
        tick();
        tick();
        chk("berr_held", berr[k], 1'b0);
        asn_v[k] = 1'b1;
        tick();
        chk("berr_release", berr[k], 1'b1);
        chk("berr_no_strobe", strobes[k], s0);
    endtask

    task automatic reset_vals(input int k, input logic [31:0] exp_dout);
        chk("reset_bus", {dsk[k], sterm[k], cback[k], berr[k], den[k]}, 6'b111110);
        chk("reset_mem", {mre[k], mwe[k], mbe[k]}, 6'b0);
        chk("reset_dout", dout[k], exp_dout);
    endtask

    initial begin
        logic        quiet;
        logic [31:0] v;
        reset = 1'b1; adr = 32'h0; wdata = 32'h0; rwn = 1'b1; dsn = 1'b1;
        size = 2'b00; cbreqn = 1'b1;
        for (int k = 0; k < 3; k++) asn_v[k] = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) reset_vals(k, 32'h0);
        reset = 1'b0;
        tick();

        // Preload all three memories through the DUT write path
        for (int w = 0; w < 16; w++) begin
            v = (w == 4) ? 32'hCAFE_BABE : $urandom;
            async_xfer(0, 32'(4 * w), 1'b0, 2'b00, v, 0);
            v = (w == 4) ? 32'h1234_5678 : $urandom;
            async_xfer(1, 32'h400 + 32'(4 * w), 1'b0, 2'b00, v, 0);
            sync_xfer(32'(4 * w), 1'b0, 2'b00, $urandom, 1'b1);
        end

        async_xfer(0, 32'h10, 1'b1, 2'b00, 32'h0, 0);
        chk("cafebabe", dout[0], 32'hCAFE_BABE);
        async_xfer(0, 32'h3, 1'b0, 2'b01, 32'h0000_005A, 0);
        async_xfer(0, 32'h1, 1'b0, 2'b10, 32'h00AB_CD00, 0);
        async_xfer(0, 32'h0, 1'b1, 2'b00, 32'h0, 1);
        chk("merged_word_lanes", dout[0][23:0], 24'hABCD5A);
        async_xfer(1, 32'h405, 1'b0, 2'b11, 32'h0011_2233, 0);
        async_xfer(1, 32'h404, 1'b1, 2'b00, 32'h0, 0);
        async_xfer(1, 32'h410, 1'b1, 2'b00, 32'h0, 3);
        chk("ws3_data", dout[1], 32'h1234_5678);

        err_xfer(0, 32'h100);
        err_xfer(1, 32'h3FC);
        err_xfer(1, 32'h500);

        sync_xfer(32'h8, 1'b1, 2'b00, 32'h0, 1'b0);
        sync_xfer(32'h24, 1'b1, 2'b00, 32'h0, 1'b0);
        sync_xfer(32'h8, 1'b1, 2'b00, 32'h0, 1'b1);
        sync_xfer(32'h8, 1'b1, 2'b10, 32'h0, 1'b0);
        sync_xfer(32'h8, 1'b0, 2'b00, 32'hDEAD_BEEF, 1'b0);

        // ASn negated during ACCESS: no termination, then a normal cycle still works
        adr = 32'h10; rwn = 1'b1; size = 2'b00; asn_v[0] = 1'b0;
        tick();
        asn_v[0] = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dsk[0] != 2'b11 || den[0] != 1'b0) quiet = 1'b0;
        end
        chk("early_asn_no_term", quiet, 1'b1);
        async_xfer(0, 32'h10, 1'b1, 2'b00, 32'h0, 0);

        // Reset while the WS=3 instance sits in SETTLE
        v = dout[1];
        adr = 32'h410; rwn = 1'b1; size = 2'b00; asn_v[1] = 1'b0;
        tick();
        tick();
        reset = 1'b1; asn_v[1] = 1'b1;
        tick();
        chk("pre_reset_dout_nonzero", (v != 32'h0), 1'b1);
        reset_vals(1, 32'h0);
        reset = 1'b0;
        tick();
        async_xfer(1, 32'h410, 1'b1, 2'b00, 32'h0, 0);

        for (int it = 0; it < 40; it++) begin
            int k;
            k = int'($urandom_range(0, 1));
            async_xfer(k, base_of[k] + 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
        end
        for (int it = 0; it < 12; it++)
            sync_xfer(32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
